// File: rtl/midi_pkg.sv
// Shared MIDI definitions: event-type encoding, status byte ranges and
// per-status data length, used by the SPI MIDI receiver.
package midi_pkg;

  typedef enum logic [2:0] {
    EV_NOTE_OFF = 3'd0,
    EV_NOTE_ON  = 3'd1,
    EV_POLY_AT  = 3'd2,
    EV_CC       = 3'd3,
    EV_PROG     = 3'd4,
    EV_CHAN_AT  = 3'd5,
    EV_PITCH    = 3'd6
  } ev_type_t;

  localparam logic [7:0] ST_CHAN_MIN = 8'h80;
  localparam logic [7:0] ST_SYS_MIN  = 8'hF0;
  localparam logic [7:0] ST_RT_MIN   = 8'hF8;

  // Number of data bytes that follow a channel status byte.
  function automatic logic [1:0] data_len(input logic [3:0] hi);
    case (hi)
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: data_len = 2'd2;
      4'hC, 4'hD:                   data_len = 2'd1;
      default:                      data_len = 2'd0;
    endcase
  endfunction

  // A NOTE_ON with zero velocity is a NOTE_OFF by MIDI convention.
  function automatic ev_type_t ev_type_of(input logic [3:0] hi, input logic [6:0] d2);
    case (hi)
      4'h8:    ev_type_of = EV_NOTE_OFF;
      4'h9:    ev_type_of = (d2 == 7'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
      4'hA:    ev_type_of = EV_POLY_AT;
      4'hB:    ev_type_of = EV_CC;
      4'hC:    ev_type_of = EV_PROG;
      4'hD:    ev_type_of = EV_CHAN_AT;
      default: ev_type_of = EV_PITCH;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises SCLK/MOSI into clk, shifts bits
// MSB first on SCLK rising edges and drops partial bytes after an idle gap.
module spi_byte_rx #(
  parameter int IDLE_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  output logic       byte_strobe,
  output logic [7:0] byte_data
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(IDLE_TIMEOUT);

  logic            sclk_s1, sclk_s2, sclk_s3;
  logic            mosi_s1, mosi_s2;
  logic [6:0]      shift;
  logic [2:0]      bit_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            sclk_rise;

  assign sclk_rise = sclk_s2 && !sclk_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_s3     <= 1'b0;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      byte_strobe <= 1'b0;
      byte_data   <= '0;
    end else begin
      sclk_s1     <= sclk;
      sclk_s2     <= sclk_s1;
      sclk_s3     <= sclk_s2;
      mosi_s1     <= mosi;
      mosi_s2     <= mosi_s1;
      byte_strobe <= 1'b0;
      if (sclk_rise) begin
        idle_cnt <= '0;
        bit_cnt  <= bit_cnt + 3'd1;
        shift    <= {shift[5:0], mosi_s2};
        if (bit_cnt == 3'd7) begin
          byte_data   <= {shift, mosi_s2};
          byte_strobe <= 1'b1;
        end
      end else if (idle_cnt != TO_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else if (bit_cnt != 3'd0) begin
        // Stale partial byte: realign to the next byte boundary.
        bit_cnt <= '0;
        shift   <= '0;
      end
    end
  end

endmodule

// File: rtl/spi_midi_rx.sv
// SPI MIDI front end: bytes from spi_byte_rx are parsed (with running status)
// into channel-voice events held in a valid/ready output register.
module spi_midi_rx
  import midi_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPI_sclk,
  input  logic       SPI_mosi,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [2:0] event_type,
  output logic [3:0] event_chan,
  output logic [6:0] event_d1,
  output logic [6:0] event_d2,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       overrun
);

  logic [7:0] run_status;
  logic       rs_valid;
  logic       idx;
  logic [6:0] d1_hold;
  logic [1:0] need;

  logic       emit;
  ev_type_t   em_type;
  logic [6:0] em_d1, em_d2;

  spi_byte_rx #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .TO_W        (TO_W)
  ) u_byte_rx (
    .clk        (clk),
    .reset      (reset),
    .sclk       (SPI_sclk),
    .mosi       (SPI_mosi),
    .byte_strobe(byte_strobe),
    .byte_data  (byte_data)
  );

  assign need = data_len(run_status[7:4]);

  always_comb begin
    emit  = 1'b0;
    em_d1 = '0;
    em_d2 = '0;
    if (byte_strobe && !byte_data[7] && rs_valid) begin
      if (idx) begin
        emit  = 1'b1;
        em_d1 = d1_hold;
        em_d2 = byte_data[6:0];
      end else if (need == 2'd1) begin
        emit  = 1'b1;
        em_d1 = byte_data[6:0];
      end
    end
    em_type = ev_type_of(run_status[7:4], em_d2);
  end

  // Realtime bytes (>= F8) leave all parser state untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_status <= '0;
      rs_valid   <= 1'b0;
      idx        <= 1'b0;
      d1_hold    <= '0;
    end else if (byte_strobe && byte_data < ST_RT_MIN) begin
      if (byte_data >= ST_SYS_MIN) begin
        rs_valid <= 1'b0;
        idx      <= 1'b0;
      end else if (byte_data >= ST_CHAN_MIN) begin
        run_status <= byte_data;
        rs_valid   <= 1'b1;
        idx        <= 1'b0;
      end else if (rs_valid) begin
        if (emit) begin
          idx <= 1'b0;
        end else begin
          d1_hold <= byte_data[6:0];
          idx     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_type  <= '0;
      event_chan  <= '0;
      event_d1    <= '0;
      event_d2    <= '0;
      overrun     <= 1'b0;
    end else if (emit && (!event_valid || event_ready)) begin
      event_valid <= 1'b1;
      event_type  <= em_type;
      event_chan  <= run_status[3:0];
      event_d1    <= em_d1;
      event_d2    <= em_d2;
    end else begin
      if (emit) overrun <= 1'b1;
      if (event_valid && event_ready) event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_midi_rx.sv
// Bench for spi_midi_rx: drives SPI bytes, predicts events from MIDI rules
// and checks every accepted event and assembled byte.
module tb_spi_midi_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SPI_sclk = 1'b0;
  logic       SPI_mosi = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [2:0] event_type;
  logic [3:0] event_chan;
  logic [6:0] event_d1, event_d2;
  logic       byte_strobe;
  logic [7:0] byte_data;
  logic       overrun;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int t;
    int ch;
    int d1;
    int d2;
  } ev_t;

  ev_t exp_q[$];
  int  byte_q[$];
  int  last_ev = -1;
  int  exp_ovr = 0;

  int  rs = -1;
  int  need = 0;
  int  got = 0;
  int  dat[2];

  always #5 clk = ~clk;

  spi_midi_rx dut (
    .clk        (clk),
    .reset      (reset),
    .SPI_sclk   (SPI_sclk),
    .SPI_mosi   (SPI_mosi),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_type (event_type),
    .event_chan (event_chan),
    .event_d1   (event_d1),
    .event_d2   (event_d2),
    .byte_strobe(byte_strobe),
    .byte_data  (byte_data),
    .overrun    (overrun)
  );

  function automatic int pack(int t, int ch, int d1, int d2);
    return (t << 18) | (ch << 14) | (d1 << 7) | d2;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MIDI reference: what a receiver must emit for each completed byte.
  task automatic model_byte(int b, bit will_accept);
    ev_t e;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs = -1;
      got = 0;
      return;
    end
    if (b >= 'h80) begin
      rs = b;
      got = 0;
      need = ((b >> 4) == 'hC || (b >> 4) == 'hD) ? 1 : 2;
      return;
    end
    if (rs < 0) return;
    dat[got] = b;
    got++;
    if (got == need) begin
      got  = 0;
      e.ch = rs & 15;
      e.d1 = dat[0];
      e.d2 = (need == 2) ? dat[1] : 0;
      e.t  = (rs >> 4) - 8;
      if (e.t == 1 && e.d2 == 0) e.t = 0;
      if (exp_q.size() > 0 && !will_accept) exp_ovr = 1;
      else exp_q.push_back(e);
    end
  endtask

  task automatic send_bits(logic [7:0] b, int n, bit lat, bit raise);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_sclk = 1'b0;
      SPI_mosi = b[i];
      repeat (20) @(posedge clk);
      #1;
      SPI_sclk = 1'b1;
      if (i == 0 && n == 8) begin
        byte_q.push_back(int'(b));
        model_byte(int'(b), event_ready || raise);
      end
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (i == 0 && lat && k == 3) begin
          chk("lat_strobe_e1", int'(byte_strobe), 1);
          chk("lat_valid_e1", int'(event_valid), 0);
        end
        if (i == 0 && lat && k == 4) chk("lat_valid_e2", int'(event_valid), 1);
        if (i == 0 && raise && k == 3) event_ready = 1'b1;
      end
    end
    SPI_sclk = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    send_bits(b, 8, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted event and every assembled byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (byte_strobe) begin
          if (byte_q.size() == 0) chk("byte_unexpected", int'(byte_data), -1);
          else chk("byte_data", int'(byte_data), byte_q.pop_front());
        end
        if (event_valid && event_ready) begin
          last_ev = pack(int'(event_type), int'(event_chan), int'(event_d1), int'(event_d2));
          if (exp_q.size() == 0) begin
            chk("event_unexpected", last_ev, -1);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event", last_ev, pack(e.t, e.ch, e.d1, e.d2));
          end
        end
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_event", pack(int'(event_type), int'(event_chan), int'(event_d1), int'(event_d2)), 0);
    chk("rst_strobe", int'(byte_strobe), 0);
    chk("rst_byte", int'(byte_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    idle(5);

    event_ready = 1'b1;
    send_byte(8'h90);
    send_byte(8'h3C);
    send_bits(8'h64, 8, 1'b1, 1'b0);
    idle(10);
    chk("lit_note_on", last_ev, pack(1, 0, 'h3C, 'h64));

    send_byte(8'h93);
    send_byte(8'h40);
    send_byte(8'h50);
    send_byte(8'h41);
    send_byte(8'h00);
    idle(10);
    chk("lit_running_off", last_ev, pack(0, 3, 'h41, 0));

    send_byte(8'hC5);
    send_byte(8'h07);
    idle(10);
    chk("lit_prog", last_ev, pack(4, 5, 7, 0));
    send_byte(8'hE0);
    send_byte(8'h00);
    send_byte(8'hF8);
    send_byte(8'h40);
    idle(10);
    chk("lit_pitch", last_ev, pack(6, 0, 0, 'h40));

    send_bits(8'h16, 5, 1'b0, 1'b0);
    idle(1100);
    send_byte(8'hB1);
    send_byte(8'h07);
    send_byte(8'h7F);
    idle(10);
    chk("lit_cc", last_ev, pack(3, 1, 7, 'h7F));
    send_byte(8'hF0);
    send_byte(8'h10);
    send_byte(8'h20);
    idle(10);
    chk("sysex_no_event", last_ev, pack(3, 1, 7, 'h7F));
    chk("sysex_valid", int'(event_valid), 0);

    event_ready = 1'b0;
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'h40);
    send_byte(8'h91);
    send_byte(8'h3D);
    send_byte(8'h41);
    idle(5);
    chk("ovr_set", int'(overrun), exp_ovr);
    chk("ovr_held_valid", int'(event_valid), 1);
    chk("ovr_held_event", pack(int'(event_type), int'(event_chan), int'(event_d1), int'(event_d2)),
        pack(1, 0, 'h3C, 'h40));
    send_byte(8'h92);
    send_byte(8'h3E);
    send_bits(8'h42, 8, 1'b0, 1'b1);
    idle(5);
    chk("coincide_valid_drop", int'(event_valid), 0);
    chk("coincide_overrun", int'(overrun), 1);
    chk("lit_third", last_ev, pack(1, 2, 'h3E, 'h42));

    send_byte(8'h90);
    send_byte(8'h3C);
    reset = 1'b1;
    rs = -1;
    got = 0;
    exp_ovr = 0;
    byte_q.delete();
    idle(2);
    chk("mid_rst_valid", int'(event_valid), 0);
    chk("mid_rst_event", pack(int'(event_type), int'(event_chan), int'(event_d1), int'(event_d2)), 0);
    chk("mid_rst_byte", int'(byte_data), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    idle(3);
    send_byte(8'h30);
    idle(20);
    chk("post_rst_valid", int'(event_valid), 0);
    chk("post_rst_overrun", int'(overrun), exp_ovr);
    chk("events_left", exp_q.size(), 0);
    chk("bytes_left", byte_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_midi_rx.md
Name: spi_midi_rx

Overview:
- Front-end stage between the external SPI pins (SPI_sclk, SPI_mosi) and the voice logic inside midi_synth.
- Synchronises the asynchronous SPI bit stream into the clk domain and assembles bytes, MSB first, sampled on SCLK rising edge (mode 0, no chip select).
- Frames bytes with an idle timeout.
- Parses the MIDI channel-voice byte stream, including running status, into single-cycle-registered events with a valid/ready handshake.

Parameters:
- IDLE_TIMEOUT, 1024, clk cycles without an SCLK rising edge after which the partial-byte bit counter is cleared.
- TO_W, 11, width of the idle counter; must satisfy 2^TO_W > IDLE_TIMEOUT.

Ports:
- clk  in  1  system clock (PLL output)
- reset  in  1  asynchronous, active-high reset
- SPI_sclk  in  1  raw SPI clock, asynchronous to clk
- SPI_mosi  in  1  raw SPI data, asynchronous to clk
- event_valid  out  1  event register holds an unconsumed event
- event_ready  in  1  consumer accepts the event when valid&&ready
- event_type  out  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CC, 4 PROG, 5 CHAN_AT, 6 PITCH
- event_chan  out  4  MIDI channel (status low nibble)
- event_d1  out  7  first data byte
- event_d2  out  7  second data byte; 0 for 1-byte messages
- byte_strobe  out  1  one-cycle pulse per assembled byte (debug)
- byte_data  out  8  last assembled byte (debug)
- overrun  out  1  sticky: an event was dropped

Behaviour:
- Reset: all registers cleared asynchronously. Outputs event_valid=0, event_* =0, byte_strobe=0, byte_data=0, overrun=0. Bit counter=0, running status=none, data count=0.
- Synchroniser:
  - Two flops each on SCLK and MOSI, plus a third SCLK flop for edge detection.
  - Cycle E is the edge cycle: sclk_s2=1 and sclk_s3=0.
  - In E, mosi_s2 shifts into bit 0 of the shift register and the bit counter increments.
- Byte completion: when the 8th bit shifts in during cycle E, byte_data is loaded and byte_strobe=1 in cycle E+1. The bit counter wraps to 0.
- Idle timeout:
  - The idle counter resets on every edge and saturates otherwise.
  - When it reaches IDLE_TIMEOUT with bit counter ≠0, the bit counter and shift register clear. No byte_strobe is produced.
  - At bit counter =0 the timeout has no effect.
- Parser, evaluated in the byte_strobe cycle:
  - 0x80–0xEF:
    - Stores running status.
    - Expected data count: 2 for upper nibbles 8, 9, A, B, E; 1 for C, D.
    - Clears the data index.
    - A status byte arriving mid-message aborts the partial message.
  - 0xF0–0xF7: running status cleared (none). Subsequent data bytes are ignored until the next channel status byte.
  - 0xF8–0xFF (realtime): ignored entirely; running status and data index unchanged, even mid-message.
  - Data byte (bit7=0) with running status=none: ignored.
  - Data byte with running status set: stored at the data index, which then increments. When the index reaches the expected count, an event is emitted and the index returns to 0. Running status is retained.
  - NOTE_ON with d2=0 is emitted as type NOTE_OFF, with d2=0.
- Event emission:
  - The event register loads at the end of the byte_strobe cycle. event_valid=1 from cycle E+2 onward.
  - It holds until the cycle where event_valid&&event_ready; it clears next cycle unless a new event loads in that same cycle.
  - Simultaneous accept and new event: the new event loads and valid stays 1, with no drop.
  - New event while valid && !ready: the new event is discarded, the held event is unchanged, and overrun←1 (sticky until reset).
- Reset mid-byte or mid-message: all partial state is discarded. A byte straddling reset is never emitted.

Decomposition:
- Shared package midi_pkg: event-type encoding constants (EV_NOTE_OFF..EV_PITCH), status-range constants (0x80, 0xF0, 0xF8), and the data-length function/table keyed on status upper nibble.
- One sub-module, spi_byte_rx: synchroniser, edge detect, shift register, bit counter, and idle timeout. Outputs byte_strobe and byte_data.
- The parser and event register stay in spi_midi_rx.

Test Plan:
- Send 0x90,0x3C,0x64 (SCLK period 40 clk), ready=1 -> one event: type 1, chan 0, d1 0x3C, d2 0x64; event_valid rises exactly 2 cycles after the final edge cycle.
- Running status: 0x93,0x40,0x50,0x41,0x00 -> NOTE_ON ch3 0x40/0x50, then NOTE_OFF ch3 0x41/0x00.
- 0xC5,0x07 then 0xE0,0x00,0x40 with an interleaved 0xF8 between 0x00 and 0x40 -> PROG ch5 d1 0x07 d2 0; PITCH ch0 d1 0x00 d2 0x40.
- 5 bits of garbage, idle 1100 cycles, then 0xB1,0x07,0x7F -> garbage discarded; CC ch1 0x07/0x7F. Also 0xF0 then 0x10,0x20 -> no event.
- ready=0, send two full NOTE_ON messages -> first held, overrun=1, second lost. Raise ready -> valid drops after the accept cycle. Accept coinciding with a third event -> third held, no extra overrun change.
- Assert reset after 2 bytes of a 3-byte message, then send the remaining byte 0x30 -> no event, all outputs 0 during reset, running status none.
